// File: rtl/sd_spi_responder.sv
// SPI-mode SD card emulator: decodes 48-bit command frames, answers R1/R3/R7,
// and streams single or multi-block reads of a deterministic byte pattern.
module sd_spi_responder #(
  parameter int          ACMD41_BUSY_COUNT  = 2,
  parameter int          NCR_BYTES          = 1,
  parameter int          READ_LATENCY_BYTES = 4,
  parameter logic [31:0] OCR_VALUE          = 32'hC0FF8000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        sclk,
  input  logic        mosi,
  output logic        miso,
  output logic [5:0]  last_cmd,
  output logic [15:0] blocks_sent,
  output logic        illegal_cmd
);
  typedef enum logic [2:0] {
    LISTEN, RESP, DATA_WAIT, DATA_TOKEN, DATA_PAYLOAD, DATA_CRC
  } state_t;

  localparam logic [3:0] NCR_INIT = 4'(NCR_BYTES);
  localparam logic [7:0] LAT_INIT = 8'(READ_LATENCY_BYTES);
  localparam logic [7:0] BUSY_MAX = 8'(ACMD41_BUSY_COUNT);

  logic [1:0]  cs_sync, sclk_sync, mosi_sync;
  logic        sclk_prev;
  logic        sel, rise, fall, din;
  state_t      state, resp_next;
  logic [2:0]  bit_cnt;
  logic        byte_end;
  logic [6:0]  tx_sh;
  logic [7:0]  next_byte;
  logic        in_frame;
  logic [5:0]  frame_cnt;
  logic [46:0] frame_sh;
  logic        frame_ok;
  logic [5:0]  idx;
  logic [31:0] arg;
  logic        card_idle, app_cmd, multi, crc_second;
  logic [7:0]  acmd41_cnt;
  logic [3:0]  ncr_cnt;
  logic [2:0]  resp_left;
  logic [39:0] resp_buf;
  logic [7:0]  wait_cnt;
  logic [8:0]  pay_cnt;
  logic [31:0] addr;

  assign sel  = ~cs_sync[1];
  assign rise = sclk_sync[1] & ~sclk_prev;
  assign fall = ~sclk_sync[1] & sclk_prev;
  assign din  = mosi_sync[1];

  // frame_sh holds frame bits 47..1; the bit on the 48th rise is the end bit
  assign idx      = frame_sh[44:39];
  assign arg      = frame_sh[38:7];
  assign frame_ok = sel && rise && in_frame && (frame_cnt == 6'd47) &&
                    !frame_sh[46] && frame_sh[45] && din;

  always_comb begin
    next_byte = 8'hFF;
    case (state)
      RESP:         if (ncr_cnt == 4'd0) next_byte = resp_buf[39:32];
      DATA_TOKEN:   next_byte = 8'hFE;
      DATA_PAYLOAD: next_byte = addr[7:0] + pay_cnt[7:0];
      default:      next_byte = 8'hFF;
    endcase
  end

  always_ff @(posedge clk) begin
    cs_sync     <= {cs_sync[0], cs};
    sclk_sync   <= {sclk_sync[0], sclk};
    mosi_sync   <= {mosi_sync[0], mosi};
    sclk_prev   <= sclk_sync[1];
    illegal_cmd <= 1'b0;
    if (rst) begin
      cs_sync     <= 2'b11;
      sclk_sync   <= 2'b00;
      mosi_sync   <= 2'b11;
      sclk_prev   <= 1'b0;
      state       <= LISTEN;
      resp_next   <= LISTEN;
      miso        <= 1'b1;
      tx_sh       <= 7'h7F;
      bit_cnt     <= 3'd0;
      byte_end    <= 1'b0;
      in_frame    <= 1'b0;
      frame_cnt   <= 6'd0;
      frame_sh    <= '0;
      last_cmd    <= 6'd0;
      blocks_sent <= 16'd0;
      card_idle   <= 1'b1;
      app_cmd     <= 1'b0;
      acmd41_cnt  <= 8'd0;
      multi       <= 1'b0;
      crc_second  <= 1'b0;
      ncr_cnt     <= 4'd0;
      resp_left   <= 3'd0;
      resp_buf    <= '0;
      wait_cnt    <= 8'd0;
      pay_cnt     <= 9'd0;
      addr        <= 32'd0;
    end else if (!sel) begin
      // deselect aborts any transfer but keeps initialisation progress
      bit_cnt   <= 3'd0;
      byte_end  <= 1'b0;
      tx_sh     <= 7'h7F;
      miso      <= 1'b1;
      in_frame  <= 1'b0;
      frame_cnt <= 6'd0;
      state     <= LISTEN;
    end else begin
      if (rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) byte_end <= 1'b1;
        if (in_frame) begin
          frame_sh  <= {frame_sh[45:0], din};
          frame_cnt <= frame_cnt + 6'd1;
          if (frame_cnt == 6'd47) in_frame <= 1'b0;
        end else if (state != RESP && !din) begin
          in_frame  <= 1'b1;
          frame_cnt <= 6'd1;
          frame_sh  <= {frame_sh[45:0], din};
        end
      end

      if (frame_ok) begin
        last_cmd <= idx;
        if (state == LISTEN) begin
          state     <= RESP;
          ncr_cnt   <= NCR_INIT;
          resp_next <= LISTEN;
          resp_left <= 3'd1;
          resp_buf  <= {7'b0, card_idle, 32'h0};
          app_cmd   <= 1'b0;
          case (idx)
            6'd0: begin
              card_idle  <= 1'b1;
              acmd41_cnt <= 8'd0;
              resp_buf   <= {8'h01, 32'h0};
            end
            6'd8: begin
              resp_left <= 3'd5;
              resp_buf  <= {7'b0, card_idle, 16'h0, 4'h0, arg[11:0]};
            end
            6'd16: ;
            6'd55: app_cmd <= 1'b1;
            6'd41: begin
              if (!app_cmd) begin
                illegal_cmd <= 1'b1;
                resp_buf    <= {5'b0, 1'b1, 1'b0, card_idle, 32'h0};
              end else if (acmd41_cnt < BUSY_MAX) begin
                acmd41_cnt <= acmd41_cnt + 8'd1;
                resp_buf   <= {8'h01, 32'h0};
              end else begin
                card_idle <= 1'b0;
                resp_buf  <= 40'h0;
              end
            end
            6'd58: begin
              resp_left <= 3'd5;
              resp_buf  <= {7'b0, card_idle, OCR_VALUE};
            end
            6'd17, 6'd18: begin
              if (card_idle) begin
                resp_buf <= {8'h05, 32'h0};
              end else begin
                resp_buf  <= 40'h0;
                resp_next <= DATA_WAIT;
                addr      <= arg;
                multi     <= (idx == 6'd18);
              end
            end
            default: begin
              illegal_cmd <= 1'b1;
              resp_buf    <= {5'b0, 1'b1, 1'b0, card_idle, 32'h0};
            end
          endcase
        end else if (multi && idx == 6'd12) begin
          // one stuff byte after the current byte, then R1
          state     <= RESP;
          ncr_cnt   <= 4'd1;
          resp_left <= 3'd1;
          resp_buf  <= 40'h0;
          resp_next <= LISTEN;
        end
      end

      if (fall) begin
        if (byte_end) begin
          byte_end <= 1'b0;
          tx_sh    <= next_byte[6:0];
          miso     <= next_byte[7];
          case (state)
            RESP: begin
              if (ncr_cnt != 4'd0) begin
                ncr_cnt <= ncr_cnt - 4'd1;
              end else begin
                resp_buf  <= {resp_buf[31:0], 8'hFF};
                resp_left <= resp_left - 3'd1;
                if (resp_left == 3'd1) begin
                  state    <= resp_next;
                  wait_cnt <= LAT_INIT;
                end
              end
            end
            DATA_WAIT: begin
              wait_cnt <= wait_cnt - 8'd1;
              if (wait_cnt == 8'd1) state <= DATA_TOKEN;
            end
            DATA_TOKEN: begin
              state   <= DATA_PAYLOAD;
              pay_cnt <= 9'd0;
            end
            DATA_PAYLOAD: begin
              pay_cnt <= pay_cnt + 9'd1;
              if (pay_cnt == 9'd511) begin
                state      <= DATA_CRC;
                crc_second <= 1'b0;
              end
            end
            DATA_CRC: begin
              crc_second <= 1'b1;
              if (crc_second) begin
                blocks_sent <= blocks_sent + 16'd1;
                if (multi) begin
                  addr     <= addr + 32'd1;
                  wait_cnt <= LAT_INIT;
                  state    <= DATA_WAIT;
                end else begin
                  state <= LISTEN;
                end
              end
            end
            default: ;
          endcase
        end else begin
          tx_sh <= {tx_sh[5:0], 1'b1};
          miso  <= tx_sh[6];
        end
      end
    end
  end
endmodule
